capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
Acquisition front end feeding the trace RAM interface. Arms on a command, decimates the sample clock, and writes a circular 3-channel trace buffer. It fills the pre-trigger region, then waits for a qualified trigger edge and captures a programmable number of post-trigger samples. It then reports trace_end, the address of the last sample written, so the dump stage can replay the trace oldest-first starting from trace_end+1.

Parameters:
ADDR_W, 9, trace buffer address width; DEPTH = 2**ADDR_W entries; address wraps modulo DEPTH.
DEC_W, 4, width of decimator; the sample period is 2**decimator clocks.
AUTO_TIMEOUT, 16'd50000, auto-trigger timeout in sample strobes. Used only with AUTO_TRIG_EN.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, synchronous active-low.
cap_start  in  1  one-cycle pulse that starts a capture. Ignored while dump_busy is high.
dump_busy  in  1  high while the RAM interface is dumping.
trig_src  in  2  trigger source: 0=trig1, 1=trig2, 2=force (trigger immediately on arming), 3=disabled.
trig_edge  in  1  1=rising edge, 0=falling edge.
trig1  in  1  synchronized channel-1 comparator output.
trig2  in  1  synchronized channel-2 comparator output.
trig_pos  in  ADDR_W  number of post-trigger samples. 0 is treated as 1.
decimator  in  DEC_W  log2 of the sample period.
clr_cap_done  in  1  clears capture_done.
we  out  1  high for the whole capture (states WRT, ARMED, POST).
cap_en  out  1  one-cycle write strobe per decimated sample.
cap_addr  out  ADDR_W  buffer address written while cap_en is high.
trace_end  out  ADDR_W  address of the final sample of the last completed capture.
armed  out  1  high in ARMED.
triggered  out  1  high in POST and DONE.
capture_done  out  1  sticky completion flag.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; we, cap_en, armed, triggered, capture_done = 0; cap_addr, trace_end, all counters = 0; trigger history flop = 0.
- Decimation:
  - dec_cnt clears on entry to WRT.
  - sample strobe when dec_cnt == 2**decimator-1; dec_cnt then wraps to 0.
  - decimator=0 gives a strobe every clock.
- cap_en = strobe AND state in {WRT, ARMED, POST}. On each cap_en, cap_addr advances by 1 on the next clk, wrapping DEPTH-1 -> 0.
- Trigger edge:
  - prev flop samples the selected input every clock.
  - edge = sel & ~prev when trig_edge=1; edge = ~sel & prev when trig_edge=0.
  - Edges are evaluated only in ARMED; edges in WRT are ignored.
- pre_need = DEPTH - max(trig_pos,1), a full ADDR_W+1-bit compare.
- States:
  - IDLE: on cap_start & ~dump_busy -> WRT next cycle. capture_done cleared, cap_addr = 0, pre_cnt = 0. we is high from the first WRT cycle.
  - WRT: count writes in pre_cnt. When the pre_cnt-th write makes pre_cnt == pre_need -> ARMED.
  - ARMED: an edge in cycle N -> POST in N+1, post_cnt = 0. trig_src=2 -> POST on the cycle after entry. trig_src=3 -> remain in ARMED indefinitely.
  - POST: count writes. The write that makes post_cnt == max(trig_pos,1) sets trace_end = that write's cap_addr -> DONE next cycle.
  - DONE: we = 0, capture_done = 1, triggered = 1. cap_start (with ~dump_busy) -> WRT, clearing capture_done and triggered. clr_cap_done clears capture_done and returns to IDLE.
- Simultaneous cap_start and clr_cap_done in DONE: cap_start wins.
- cap_start while in WRT, ARMED or POST: ignored.
- Reset mid-capture: immediate return to the reset state. trace_end is not retained.
- trace_end is stable outside POST. The next capture overwrites it only at its completion.

Optional Feature:
AUTO_TRIG_EN:
- When defined: an ARMED-state counter counts sample strobes. It reaches AUTO_TIMEOUT without an edge -> forced trigger, same timing as an edge. The counter clears on ARMED entry.
- When undefined: there is no counter, and ARMED waits only for an edge or trig_src=2.

Test Plan:
1. decimator=0, trig_pos=100, trig_src=0, rising. cap_start, then a trig1 rise 20 cycles after armed -> 412 pre-trigger writes plus 100 post-trigger writes. capture_done=1 and we=0 on the cycle after the final write. trace_end equals the final write's address.
2. decimator=3 -> cap_en pulses exactly every 8 clocks. cap_addr wraps 511 -> 0 across a second capture without a glitch.
3. trig1 rises during WRT -> ignored, armed stays 0. A falling-edge config with trig2 dropping 1->0 in ARMED -> POST the next cycle.
4. trig_pos=0 -> treated as 1: 511 pre-trigger writes, one post-trigger write, trace_end = the address of that write.
5. rst_n low for one clock mid-POST -> all outputs zero the following cycle. cap_start while dump_busy=1 -> remains IDLE.
6. With AUTO_TRIG_EN, AUTO_TIMEOUT=10, trig_src=0 and no edge -> POST entered after 10 ARMED strobes. Without the macro -> remains ARMED after 1000 strobes.

Source files
------------

// File: rtl/capture_ctrl.sv
// Capture controller: decimated circular trace writer with pre/post-trigger regions.
// Define AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT armed sample strobes.
module capture_ctrl #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DEC_W        = 4,
  parameter logic [15:0] AUTO_TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_start,
  input  logic              dump_busy,
  input  logic [1:0]        trig_src,
  input  logic              trig_edge,
  input  logic              trig1,
  input  logic              trig2,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  input  logic              clr_cap_done,
  output logic              we,
  output logic              cap_en,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [ADDR_W-1:0] trace_end,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done
);

  // Wide enough to hold 2**decimator-1 for every decimator value.
  localparam int unsigned DecCntW = 1 << DEC_W;
  localparam logic [ADDR_W:0] DepthW = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {StIdle, StWrt, StArmed, StPost, StDone} state_e;

  state_e               state_q, state_d;
  logic [DecCntW-1:0]   dec_cnt_q, dec_cnt_d, dec_mask;
  logic [ADDR_W-1:0]    cap_addr_q, cap_addr_d;
  logic [ADDR_W-1:0]    trace_end_q, trace_end_d;
  logic [ADDR_W:0]      pre_cnt_q, pre_cnt_d, pre_cnt_inc;
  logic [ADDR_W:0]      post_cnt_q, post_cnt_d, post_cnt_inc;
  logic [ADDR_W:0]      pre_need, post_need;
  logic [ADDR_W-1:0]    tp_eff;
  logic                 prev_q, sel, edge_hit, strobe, capturing, start_ok, auto_fire;

  assign dec_mask  = ~({DecCntW{1'b1}} << decimator);
  assign strobe    = (dec_cnt_q == dec_mask);
  assign capturing = (state_q == StWrt) || (state_q == StArmed) || (state_q == StPost);
  assign start_ok  = cap_start && !dump_busy;

  always_comb begin
    tp_eff = trig_pos;
    if (trig_pos == '0) tp_eff = ADDR_W'(1);
  end

  assign post_need    = {1'b0, tp_eff};
  assign pre_need     = DepthW - post_need;
  assign pre_cnt_inc  = pre_cnt_q + 1'b1;
  assign post_cnt_inc = post_cnt_q + 1'b1;

  always_comb begin
    sel = 1'b0;
    case (trig_src)
      2'd0:    sel = trig1;
      2'd1:    sel = trig2;
      default: sel = 1'b0;
    endcase
  end

  assign edge_hit = trig_edge ? (sel & ~prev_q) : (~sel & prev_q);

`ifdef AUTO_TRIG_EN
  logic [15:0] auto_cnt_q, auto_cnt_d;

  // Held at zero outside ARMED so every arming starts a fresh timeout.
  always_comb begin
    auto_cnt_d = '0;
    auto_fire  = 1'b0;
    if (state_q == StArmed) begin
      auto_cnt_d = auto_cnt_q;
      if (strobe) begin
        auto_cnt_d = auto_cnt_q + 1'b1;
        auto_fire  = (auto_cnt_d == AUTO_TIMEOUT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) auto_cnt_q <= '0;
    else        auto_cnt_q <= auto_cnt_d;
  end
`else
  logic unused_auto_timeout;
  assign unused_auto_timeout = ^AUTO_TIMEOUT;
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dec_cnt_d   = strobe ? '0 : dec_cnt_q + 1'b1;
    cap_addr_d  = cap_en ? cap_addr_q + 1'b1 : cap_addr_q;
    trace_end_d = trace_end_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d    = StWrt;
          dec_cnt_d  = '0;
          cap_addr_d = '0;
          pre_cnt_d  = '0;
        end
      end
      StWrt: begin
        if (cap_en) begin
          pre_cnt_d = pre_cnt_inc;
          if (pre_cnt_inc == pre_need) state_d = StArmed;
        end
      end
      StArmed: begin
        if (edge_hit || (trig_src == 2'd2) || auto_fire) begin
          state_d    = StPost;
          post_cnt_d = '0;
        end
      end
      StPost: begin
        if (cap_en) begin
          post_cnt_d = post_cnt_inc;
          if (post_cnt_inc == post_need) begin
            trace_end_d = cap_addr_q;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        // A restart keeps cap_addr running so the buffer stays circular.
        if (start_ok) begin
          state_d   = StWrt;
          dec_cnt_d = '0;
          pre_cnt_d = '0;
        end else if (clr_cap_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dec_cnt_q   <= '0;
      cap_addr_q  <= '0;
      trace_end_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      prev_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_cnt_q   <= dec_cnt_d;
      cap_addr_q  <= cap_addr_d;
      trace_end_q <= trace_end_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      prev_q      <= sel;
    end
  end

  assign we           = capturing;
  assign cap_en       = strobe && capturing;
  assign cap_addr     = cap_addr_q;
  assign trace_end    = trace_end_q;
  assign armed        = (state_q == StArmed);
  assign triggered    = (state_q == StPost) || (state_q == StDone);
  assign capture_done = (state_q == StDone);

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: phase-level reference model checked every cycle plus directed literals.
module tb_capture_ctrl;
  localparam int DEPTH = 512;
  localparam int TMO   = 10;
`ifdef AUTO_TRIG_EN
  localparam int T1Arm = 10;
  localparam int T1End = 9;
  localparam int T3End = 30;
`else
  localparam int T1Arm = 21;
  localparam int T1End = 20;
  localparam int T3End = 52;
`endif
  localparam int PI = 0, PW = 1, PA = 2, PP = 3, PD = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cap_start = 1'b0, dump_busy = 1'b0, trig_edge = 1'b1;
  logic [1:0] trig_src = 2'd3;
  logic       trig1 = 1'b0, trig2 = 1'b0, clr_cap_done = 1'b0;
  logic [8:0] trig_pos = 9'd0;
  logic [3:0] decimator = 4'd0;
  logic       we, cap_en, armed, triggered, capture_done;
  logic [8:0] cap_addr, trace_end;

  always #5 clk = ~clk;

  capture_ctrl #(.ADDR_W(9), .DEC_W(4), .AUTO_TIMEOUT(16'(TMO))) dut (
    .clk(clk), .rst_n(rst_n), .cap_start(cap_start), .dump_busy(dump_busy),
    .trig_src(trig_src), .trig_edge(trig_edge), .trig1(trig1), .trig2(trig2),
    .trig_pos(trig_pos), .decimator(decimator), .clr_cap_done(clr_cap_done),
    .we(we), .cap_en(cap_en), .cap_addr(cap_addr), .trace_end(trace_end),
    .armed(armed), .triggered(triggered), .capture_done(capture_done)
  );

  // Reference model: phase, clocks since capture start, write tallies.
  int m_ph, m_tick, m_pre, m_post, m_auto, m_addr, m_end;
  bit m_prev;

  function automatic bit m_cap(input int ph);
    return (ph == PW) || (ph == PA) || (ph == PP);
  endfunction

  always @(posedge clk) begin : model
    int per, tp, nph;
    bit stb, sel, edg;
    if (!rst_n) begin
      m_ph = PI; m_tick = 0; m_pre = 0; m_post = 0; m_auto = 0; m_addr = 0; m_end = 0;
      m_prev = 1'b0;
    end else begin
      per = 1 << decimator;
      tp  = (trig_pos == 9'd0) ? 1 : int'(trig_pos);
      stb = m_cap(m_ph) && ((m_tick % per) == per - 1);
      sel = (trig_src == 2'd0) ? trig1 : (trig_src == 2'd1) ? trig2 : 1'b0;
      edg = trig_edge ? (sel && !m_prev) : (!sel && m_prev);
      m_prev = sel;
      nph = m_ph;
      case (m_ph)
        PI: if (cap_start && !dump_busy) begin nph = PW; m_addr = 0; m_pre = 0; end
        PW: if (stb) begin
              m_pre++;
              if (m_pre == DEPTH - tp) nph = PA;
            end
        PA: begin
              if (stb) m_auto++;
              if (edg || trig_src == 2'd2) nph = PP;
`ifdef AUTO_TRIG_EN
              if (m_auto == TMO) nph = PP;
`endif
              if (nph == PP) m_post = 0;
            end
        PP: if (stb) begin
              m_post++;
              if (m_post == tp) begin m_end = m_addr; nph = PD; end
            end
        PD: if (cap_start && !dump_busy) begin nph = PW; m_pre = 0; end
            else if (clr_cap_done) nph = PI;
        default: nph = PI;
      endcase
      if (stb) m_addr = (m_addr + 1) % DEPTH;
      if (nph == PA && m_ph != PA) m_auto = 0;
      m_tick = (nph == PW && m_ph != PW) ? 0 : m_tick + 1;
      m_ph = nph;
    end
  end

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  int n_wrt = 0, n_arm = 0, n_post = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int per;
    bit e_we, e_en;
    if (!chk_en) return;
    per  = 1 << decimator;
    e_we = m_cap(m_ph);
    e_en = e_we && ((m_tick % per) == per - 1);
    check("model we", 32'(we), 32'(e_we));
    check("model cap_en", 32'(cap_en), 32'(e_en));
    check("model cap_addr", 32'(cap_addr), 32'(m_addr));
    check("model trace_end", 32'(trace_end), 32'(m_end));
    check("model armed", 32'(armed), 32'(m_ph == PA));
    check("model triggered", 32'(triggered), 32'(m_ph == PP || m_ph == PD));
    check("model capture_done", 32'(capture_done), 32'(m_ph == PD));
    if (cap_en) begin
      if (armed) n_arm++;
      else if (triggered) n_post++;
      else n_wrt++;
    end
  endtask

  // Advance one cycle; sample and compare 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return armed;
      1:       return triggered;
      default: return capture_done;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string name);
    int n = 0;
    while (!sig(which) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(sig(which)), 32'd1);
  endtask

  task automatic pulse_start();
    cap_start = 1'b1;
    step();
    cap_start = 1'b0;
  endtask

  initial begin
    int s_w, s_a, s_p, cyc, last, last_addr, pulses, gap_bad, wraps;
    step();
    chk_en = 1'b1;
    step();
    check("reset we", 32'(we), 0);
    check("reset cap_addr", 32'(cap_addr), 0);
    check("reset trace_end", 32'(trace_end), 0);
    check("reset capture_done", 32'(capture_done), 0);
    rst_n = 1'b1;
    step();

    // 1: rising trig1 20 cycles after arming.
    decimator = 4'd0; trig_pos = 9'd100; trig_src = 2'd0; trig_edge = 1'b1;
    s_w = n_wrt; s_a = n_arm; s_p = n_post;
    pulse_start();
    wait_for(0, 1000, "t1 armed");
    repeat (20) step();
    trig1 = 1'b1;
    wait_for(2, 1000, "t1 done");
    check("t1 pre writes", 32'(n_wrt - s_w), 32'd412);
    check("t1 armed writes", 32'(n_arm - s_a), 32'(T1Arm));
    check("t1 post writes", 32'(n_post - s_p), 32'd100);
    check("t1 trace_end", 32'(trace_end), 32'(T1End));
    check("t1 we at done", 32'(we), 0);

    // 2: decimate by 8, restart from DONE so cap_addr wraps.
    decimator = 4'd3; trig_src = 2'd2;
    pulse_start();
    cyc = 0; last = -1; last_addr = -1; pulses = 0; gap_bad = 0; wraps = 0;
    while (!capture_done && cyc < 6000) begin
      if (cap_en) begin
        if (last >= 0 && cyc - last != 8) gap_bad++;
        if (last_addr == 511 && cap_addr == 9'd0) wraps++;
        last = cyc; last_addr = int'(cap_addr); pulses++;
      end
      step();
      cyc++;
    end
    check("t2 done", 32'(capture_done), 32'd1);
    check("t2 pulses", 32'(pulses), 32'd512);
    check("t2 bad gaps", 32'(gap_bad), 0);
    check("t2 wraps", 32'(wraps), 32'd1);
    check("t2 trace_end", 32'(trace_end), 32'(T1End));

    // 3: trig1 edge in WRT ignored; falling trig2 edge in ARMED.
    decimator = 4'd0; trig_pos = 9'd200; trig_src = 2'd0; trig_edge = 1'b1;
    trig1 = 1'b0; trig2 = 1'b1;
    step();
    pulse_start();
    repeat (50) step();
    trig1 = 1'b1;
    step();
    check("t3 armed after wrt edge", 32'(armed), 0);
    wait_for(0, 1000, "t3 armed");
`ifndef AUTO_TRIG_EN
    repeat (30) step();
    check("t3 still armed", 32'(armed), 32'd1);
    check("t3 not triggered", 32'(triggered), 0);
    trig_src = 2'd1; trig_edge = 1'b0;
    step();
    trig2 = 1'b0;
    check("t3 armed before fall", 32'(armed), 32'd1);
    step();
    check("t3 triggered after fall", 32'(triggered), 32'd1);
`endif
    wait_for(2, 1000, "t3 done");
    check("t3 trace_end", 32'(trace_end), 32'(T3End));

    // 5: start+clear together in DONE restarts; reset mid-POST; busy blocks start.
    trig_src = 2'd0; trig_edge = 1'b1; trig1 = 1'b0; trig_pos = 9'd5;
    cap_start = 1'b1; clr_cap_done = 1'b1;
    step();
    cap_start = 1'b0; clr_cap_done = 1'b0;
    check("t5 start wins we", 32'(we), 32'd1);
    check("t5 start wins done", 32'(capture_done), 0);
    repeat (10) step();
    pulse_start();
    wait_for(0, 1000, "t5 armed");
    trig1 = 1'b1;
    wait_for(1, 50, "t5 triggered");
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5 rst we", 32'(we), 0);
    check("t5 rst cap_en", 32'(cap_en), 0);
    check("t5 rst armed", 32'(armed), 0);
    check("t5 rst triggered", 32'(triggered), 0);
    check("t5 rst capture_done", 32'(capture_done), 0);
    check("t5 rst cap_addr", 32'(cap_addr), 0);
    check("t5 rst trace_end", 32'(trace_end), 0);
    dump_busy = 1'b1;
    pulse_start();
    repeat (4) begin
      check("t5 busy stays idle", 32'(we), 0);
      step();
    end
    dump_busy = 1'b0;

    // 4: trig_pos=0 behaves as 1.
    trig_pos = 9'd0; trig_src = 2'd2;
    s_w = n_wrt; s_a = n_arm; s_p = n_post;
    pulse_start();
    wait_for(2, 2000, "t4 done");
    check("t4 pre writes", 32'(n_wrt - s_w), 32'd511);
    check("t4 armed writes", 32'(n_arm - s_a), 32'd1);
    check("t4 post writes", 32'(n_post - s_p), 32'd1);
    check("t4 trace_end", 32'(trace_end), 0);
    check("t4 cap_addr", 32'(cap_addr), 32'd1);
    clr_cap_done = 1'b1;
    step();
    clr_cap_done = 1'b0;
    check("clr capture_done", 32'(capture_done), 0);
    check("clr triggered", 32'(triggered), 0);

    // 6: no edge while armed.
    trig_src = 2'd0; trig1 = 1'b0; trig_pos = 9'd500;
    step();
    s_a = n_arm;
    pulse_start();
    wait_for(0, 100, "t6 armed");
`ifdef AUTO_TRIG_EN
    wait_for(1, 50, "t6 auto trigger");
    check("t6 armed writes", 32'(n_arm - s_a), 32'(TMO));
`else
    repeat (1000) step();
    check("t6 still armed", 32'(armed), 32'd1);
    check("t6 armed writes", 32'(n_arm - s_a), 32'd1001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
